// File: rtl/shift_pkg.sv
// Shared encodings for the universal shift register: operation modes, FSM states
// and the burst-eligibility helper.
package shift_pkg;

    localparam int unsigned MODE_W = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_HOLD  = 3'b000,
        MODE_LOAD  = 3'b001,
        MODE_SHL   = 3'b010,
        MODE_SHR   = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_HOLD2 = 3'b111
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_e;

    // Only true shift/rotate modes may be repeated as a burst.
    function automatic logic is_shift_mode(input logic [MODE_W-1:0] m);
        return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROL) ||
               (m == MODE_ROR) || (m == MODE_ASR);
    endfunction

endpackage

// File: rtl/universal_shift_reg_if.sv
// Control and data bundle of the universal shift register; master drives the
// request side, slave (the register) returns contents and burst status.
interface universal_shift_reg_if #(
    parameter int unsigned WIDTH = 8
);
    import shift_pkg::*;

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic                 PRE;
    logic                 E;
    logic [MODE_W-1:0]    mode;
    logic [WIDTH-1:0]     D;
    logic                 sin;
    logic                 start;
    logic [CNT_W-1:0]     cnt;
    logic [WIDTH-1:0]     Q;
    logic                 sout;
    logic                 busy;
    logic                 done;

    modport master (
        output PRE, E, mode, D, sin, start, cnt,
        input  Q, sout, busy, done
    );

    modport slave (
        input  PRE, E, mode, D, sin, start, cnt,
        output Q, sout, busy, done
    );

endinterface

// File: rtl/shift_unit.sv
// Combinational next-value datapath; used for both single steps and bursts so the
// two paths can never disagree on shift semantics.
module shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0]  i_q,
    input  logic [MODE_W-1:0] i_mode,
    input  logic [WIDTH-1:0]  i_d,
    input  logic              i_sin,
    input  logic              i_sout,
    output logic [WIDTH-1:0]  o_q_c,
    output logic              o_sout_c
);

    always_comb begin
        o_q_c    = i_q;
        o_sout_c = i_sout;
        case (i_mode)
            MODE_LOAD: o_q_c = i_d;
            MODE_SHL: begin
                o_q_c    = {i_q[WIDTH-2:0], i_sin};
                o_sout_c = i_q[WIDTH-1];
            end
            MODE_SHR: begin
                o_q_c    = {i_sin, i_q[WIDTH-1:1]};
                o_sout_c = i_q[0];
            end
            MODE_ROL: begin
                o_q_c    = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
                o_sout_c = i_q[WIDTH-1];
            end
            MODE_ROR: begin
                o_q_c    = {i_q[0], i_q[WIDTH-1:1]};
                o_sout_c = i_q[0];
            end
            MODE_ASR: begin
                o_q_c    = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
                o_sout_c = i_q[0];
            end
            default: begin
                o_q_c    = i_q;
                o_sout_c = i_sout;
            end
        endcase
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register with single-step operations and a counted burst engine
// (IDLE -> SHIFT -> DONE); preset aborts a burst, reset clears everything.
module universal_shift_reg
    import shift_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter logic [WIDTH-1:0] PRE_VAL = {WIDTH{1'b1}}
) (
    input  logic                 clk,
    input  logic                 rst,
    universal_shift_reg_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [MODE_W-1:0]  r_mode;
    logic [MODE_W-1:0]  w_mode_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   w_q_nxt;
    logic               r_sout;
    logic               w_sout_nxt;
    logic               r_busy;
    logic               r_done;

    logic [MODE_W-1:0]  w_unit_mode;
    logic [WIDTH-1:0]   w_unit_q;
    logic               w_unit_sout;

    // During a burst the latched mode drives the datapath, otherwise the live mode.
    assign w_unit_mode = (r_state == ST_SHIFT) ? r_mode : bus.mode;

    shift_unit #(
        .WIDTH (WIDTH)
    ) u_shift_unit (
        .i_q      (r_q),
        .i_mode   (w_unit_mode),
        .i_d      (bus.D),
        .i_sin    (bus.sin),
        .i_sout   (r_sout),
        .o_q_c    (w_unit_q),
        .o_sout_c (w_unit_sout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_HOLD;
            r_cnt   <= '0;
            r_q     <= '0;
            r_sout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_cnt   <= w_cnt_nxt;
            r_q     <= w_q_nxt;
            r_sout  <= w_sout_nxt;
            r_busy  <= (w_state_nxt == ST_SHIFT);
            r_done  <= (w_state_nxt == ST_DONE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_cnt_nxt   = r_cnt;
        w_q_nxt     = r_q;
        w_sout_nxt  = r_sout;

        if (bus.PRE) begin
            // Preset wins over any pending burst or single step and drops a running burst.
            w_q_nxt     = PRE_VAL;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start && (bus.cnt != '0) && is_shift_mode(bus.mode)) begin
                        w_mode_nxt  = bus.mode;
                        w_cnt_nxt   = bus.cnt;
                        w_state_nxt = ST_SHIFT;
                    end else if (bus.E) begin
                        w_q_nxt    = w_unit_q;
                        w_sout_nxt = w_unit_sout;
                    end
                end
                ST_SHIFT: begin
                    w_q_nxt    = w_unit_q;
                    w_sout_nxt = w_unit_sout;
                    w_cnt_nxt  = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.Q    = r_q;
    assign bus.sout = r_sout;
    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: doc/universal_shift_reg.md
UNIVERSAL_SHIFT_REG -- requirements
Module: universal_shift_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the register width in bits (minimum 2).
REQ-002 The block SHALL have parameter PRE_VAL, default {WIDTH{1'b1}}, giving the value loaded by preset.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; reset is synchronous and active-high.
REQ-005 The block SHALL have port PRE, input, 1, synchronous active-high preset.
REQ-006 The block SHALL have port E, input, 1, single-step enable.
REQ-007 The block SHALL have port mode, input, 3, operation select.
REQ-008 The block SHALL have port D, input, WIDTH, parallel load data.
REQ-009 The block SHALL have port sin, input, 1, serial input bit.
REQ-010 The block SHALL have port start, input, 1, burst request.
REQ-011 The block SHALL have port cnt, input, $clog2(WIDTH+1), requested burst shift count.
REQ-012 The block SHALL have port Q, output, WIDTH, register contents.
REQ-013 The block SHALL have port sout, output, 1, bit shifted out by the most recent shift or rotate.
REQ-014 The block SHALL have port busy, output, 1, high while a burst is running.
REQ-015 The block SHALL have port done, output, 1, one-cycle pulse when a burst completes.

Function
REQ-016 The mode encoding SHALL be: 000 hold, 001 load D, 010 SHL (sin into LSB), 011 SHR (sin into MSB), 100 ROL, 101 ROR, 110 ASR (MSB replicated), 111 hold.
REQ-017 The update priority on each edge SHALL be: rst > PRE > active burst > E-gated single operation > hold.
REQ-018 With E=1, no burst active and no rst/PRE, the block SHALL apply the selected mode once per edge; with E=0, Q SHALL hold.
REQ-019 sout SHALL take the bit leaving Q (MSB for SHL/ROL, LSB for SHR/ROR/ASR) on each shift or rotate, and SHALL hold for all other operations.
REQ-020 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-021 In IDLE, start=1 with cnt!=0 and mode in 010..110 SHALL latch mode and cnt and enter SHIFT; that edge SHALL perform no shift.
REQ-022 In IDLE, start=1 with cnt=0 or with a non-shift mode SHALL be ignored; E and mode then apply normally.
REQ-023 In SHIFT, the block SHALL perform one latched-mode shift per cycle, independent of E, and SHALL ignore E, mode, D, start and cnt.
REQ-024 After exactly cnt shifts, the FSM SHALL go to DONE.
REQ-025 In DONE, done SHALL be 1 for exactly one cycle, Q SHALL hold, start SHALL be ignored, and the FSM SHALL then return to IDLE.
REQ-026 busy SHALL be 1 exactly in SHIFT; for cnt=N, busy SHALL be high for N cycles.
REQ-027 cnt values greater than WIDTH SHALL be honoured literally; ROL/ROR wrap-around is a natural consequence.
REQ-028 PRE during SHIFT SHALL load PRE_VAL, abort the burst to IDLE and suppress done.
REQ-029 PRE in IDLE SHALL take precedence over a simultaneous E or start, which SHALL be dropped.

Reset
REQ-030 With rst=1, the next edge SHALL set Q=0, sout=0, busy=0, done=0, FSM=IDLE and clear the latched mode/count, including mid-burst.
REQ-031 No output SHALL change asynchronously to clk.

Structure
REQ-032 Package shift_pkg SHALL hold the mode encodings and the FSM state typedef.
REQ-033 A combinational sub-module shift_unit SHALL compute next Q and next sout from (Q, mode, D, sin); it SHALL be shared by single-step and burst paths.

Verification (WIDTH=8)
REQ-034 rst=1 for one edge from arbitrary state -> Q=8'h00, sout=0, busy=0, done=0.
REQ-035 PRE=1 with E=1, mode=001, D=8'h5A -> Q=8'hFF.
REQ-036 Q=8'h81, E=1: ROL -> 8'h03, sout=1; ROR -> 8'hC0, sout=1; ASR from 8'h80 -> 8'hC0, sout=0.
REQ-037 E=0, mode=001, D=8'h5A -> Q unchanged for three cycles.
REQ-038 Q=8'h01, start=1, mode=010, cnt=3, sin=0 -> busy high for 3 cycles, Q=8'h08, done pulses one cycle after the third shift, then IDLE.
REQ-039 Burst SHL cnt=5 from Q=8'h01, PRE=1 after 2 shifts -> Q=8'hFF, busy=0, done never asserted.
